// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU op sequencer.
//   state_t  - sequencer FSM states
//   opcode_t - 3-bit ALU opcode, OPC_* encodings
//   instr_t  - program store word {opcode, a, b} at the default width
//   instr_bits() - instruction width for a given operand width
package alu_seq_pkg;

  localparam int SEQ_WIDTH  = 8;
  localparam int OPC_W      = 3;
  localparam int ADDR_W     = 3;
  localparam int PROG_DEPTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_SETTLE = 3'd5
  } state_t;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_NOP = 3'd0;
  localparam opcode_t OPC_ADD = 3'd1;
  localparam opcode_t OPC_SUB = 3'd2;
  localparam opcode_t OPC_AND = 3'd3;
  localparam opcode_t OPC_OR  = 3'd4;
  localparam opcode_t OPC_XOR = 3'd5;
  localparam opcode_t OPC_SHL = 3'd6;
  localparam opcode_t OPC_SHR = 3'd7;

  typedef struct packed {
    opcode_t              opcode;
    logic [SEQ_WIDTH-1:0] a;
    logic [SEQ_WIDTH-1:0] b;
  } instr_t;

  function automatic int instr_bits(input int w);
    return OPC_W + 2 * w;
  endfunction

endpackage

// File: rtl/seq_prog_store.sv
// seq_prog_store: 8-entry instruction register file.
//   clk, reset (async, active low: clears every entry)
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - combinational read port (returns pre-write contents
//                    in the cycle of a same-index write)
module seq_prog_store
  import alu_seq_pkg::*;
#(
  parameter int DW = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [PROG_DEPTH-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetches the instruction at the generator-supplied
// address, issues it to the ALU over valid/ready, captures the result and
// pulses op_done/res_valid. After each op it waits ADDR_SETTLE cycles so the
// generator's registered address update is visible before the next fetch.
//   clk, reset (async, active low)
//   start/stop               - run control (start pulse, stop level)
//   address                  - op address from the address generator
//   prog_we/prog_addr/prog_data - program store write port
//   alu_valid/alu_ready, alu_opcode/alu_a/alu_b - ALU request
//   alu_res_valid/alu_result - ALU response
//   op_done, res_valid, res_addr, res_data, op_count, busy, err - status
// Optional: define SEQ_TIMEOUT_EN to enable the WAIT watchdog (err flag).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_SETTLE = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        prog_we,
  input  logic [ADDR_W-1:0]           prog_addr,
  input  logic [OPC_W+2*WIDTH-1:0]    prog_data,
  output logic                        alu_valid,
  input  logic                        alu_ready,
  output logic [OPC_W-1:0]            alu_opcode,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  input  logic                        alu_res_valid,
  input  logic [WIDTH-1:0]            alu_result,
  output logic                        op_done,
  output logic                        res_valid,
  output logic [ADDR_W-1:0]           res_addr,
  output logic [WIDTH-1:0]            res_data,
  output logic [7:0]                  op_count,
  output logic                        busy,
  output logic                        err
);

  localparam int IW   = instr_bits(WIDTH);
  localparam int SW   = (ADDR_SETTLE < 1) ? 1 : $clog2(ADDR_SETTLE + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  if (ADDR_SETTLE < 0 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("alu_op_sequencer: ADDR_SETTLE must be >= 0 and TIMEOUT_CYC >= 1");
  end

  typedef struct packed {
    opcode_t          opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } issue_t;

  state_t            state, nxt;
  issue_t            rd_instr, iss;
  logic [ADDR_W-1:0] cur_addr;
  logic [SW-1:0]     settle_cnt;
  logic              settle_last;
  logic              capture;
  logic              wd_expire;
  logic              to_flag;  // current DONE was reached by timeout

  seq_prog_store #(.DW(IW)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (address),
    .rdata (rd_instr)
  );

  assign settle_last = (settle_cnt == SW'(ADDR_SETTLE - 1));
  // Result arrives either in the handshake cycle itself or later in WAIT.
  assign capture = alu_res_valid &&
                   ((state == S_ISSUE && alu_ready) || state == S_WAIT);

`ifdef SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // A result arriving on the limit cycle wins over the timeout.
  assign wd_expire = (state == S_WAIT) && !alu_res_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      err_q   <= 1'b0;
      to_flag <= 1'b0;
    end else begin
      wd_cnt  <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
      err_q   <= err_q | wd_expire;
      to_flag <= wd_expire;
    end
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign to_flag   = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  nxt = S_ISSUE;
      S_ISSUE:  if (alu_ready) nxt = alu_res_valid ? S_DONE : S_WAIT;
      S_WAIT:   if (alu_res_valid || wd_expire) nxt = S_DONE;
      S_DONE: begin
        if (stop)                  nxt = S_IDLE;
        else if (ADDR_SETTLE == 0) nxt = S_FETCH;
        else                       nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (stop)             nxt = S_IDLE;
        else if (settle_last) nxt = S_FETCH;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    alu_valid = (state == S_ISSUE);
    op_done   = (state == S_DONE);
    res_valid = (state == S_DONE) && !to_flag;
    busy      = (state != S_IDLE);
  end

  // Datapath: issue registers, result capture, counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss        <= '{opcode: OPC_NOP, a: '0, b: '0};
      cur_addr   <= '0;
      res_addr   <= '0;
      res_data   <= '0;
      op_count   <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == S_FETCH) begin
        cur_addr <= address;
        iss      <= rd_instr;
      end
      if (capture) begin
        res_data <= alu_result;
        res_addr <= cur_addr;
      end
      if (state == S_DONE && !to_flag) op_count <= op_count + 8'd1;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

  assign alu_opcode = iss.opcode;
  assign alu_a      = iss.a;
  assign alu_b      = iss.b;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, stop, prog_we, alu_ready, alu_res_valid;
  logic [2:0]  address, prog_addr;
  logic [18:0] prog_data;
  logic [7:0]  alu_result;
  logic        alu_valid, op_done, res_valid, busy, err;
  logic [2:0]  alu_opcode, res_addr;
  logic [7:0]  alu_a, alu_b, res_data, op_count;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.WIDTH(8), .ADDR_SETTLE(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .address(address),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_res_valid(alu_res_valid),
    .alu_result(alu_result), .op_done(op_done), .res_valid(res_valid),
    .res_addr(res_addr), .res_data(res_data), .op_count(op_count),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [2:0] idx, input logic [2:0] opc,
                      input logic [7:0] a, input logic [7:0] b);
    prog_we = 1'b1; prog_addr = idx; prog_data = {opc, a, b};
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();          // FETCH
    start = 1'b0;
  endtask

  logic [2:0] seq [7];

  initial begin
    seq = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    reset = 1'b0; start = 0; stop = 0; address = 0; prog_we = 0; prog_addr = 0;
    prog_data = '0; alu_ready = 0; alu_res_valid = 0; alu_result = 0;
    #2;
    chk("rst_busy",     busy, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_outs",     {op_done, res_valid, res_addr, res_data, err}, 0);
    chk("rst_op_count", op_count, 0);
    tick(); tick();
    reset = 1'b1;

    // ---- basic op: ADD 3,4 at address 0
    prog(3'd0, OPC_ADD, 8'd3, 8'd4);
    prog(3'd1, OPC_SUB, 8'd20, 8'd5);
    prog(3'd2, OPC_AND, 8'hF0, 8'h3C);
    address = 3'd0;
    pulse_start();
    chk("t1_fetch_busy",  busy, 1);
    chk("t1_fetch_valid", alu_valid, 0);
    tick();          // ISSUE, two cycles after start
    chk("t1_issue_valid", alu_valid, 1);
    chk("t1_payload", {alu_opcode, alu_a, alu_b}, {OPC_ADD, 8'd3, 8'd4});
    alu_ready = 1'b1;
    tick();          // WAIT
    alu_ready = 1'b0;
    chk("t1_wait_valid", alu_valid, 0);
    alu_res_valid = 1'b1; alu_result = 8'd7;
    tick();          // DONE
    alu_res_valid = 1'b0;
    chk("t1_done", {op_done, res_valid}, 2'b11);
    chk("t1_res",  {res_addr, res_data}, {3'd0, 8'd7});
    stop = 1'b1;
    tick();          // IDLE
    chk("t1_idle", {busy, op_done, res_valid}, 0);
    chk("t1_count", op_count, 1);
    chk("t1_hold", res_data, 8'd7);
    stop = 1'b0;

    // ---- ready stall for 5 cycles, then stop during WAIT
    address = 3'd1;
    pulse_start();
    tick();          // ISSUE
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", alu_valid, 1);
      chk("t2_stall_payload", {alu_opcode, alu_a, alu_b}, {OPC_SUB, 8'd20, 8'd5});
      tick();
    end
    alu_ready = 1'b1;
    chk("t2_6th_valid", alu_valid, 1);
    tick();          // WAIT
    alu_ready = 1'b0;
    chk("t2_wait", {alu_valid, busy, op_done}, 3'b010);
    start = 1'b1;    // ignored while busy
    tick();
    start = 1'b0;
    stop = 1'b1;     // does not abort WAIT
    tick();
    chk("t2_wait_hold", {alu_valid, busy, op_done}, 3'b010);
    alu_res_valid = 1'b1; alu_result = 8'd15;
    tick();          // DONE
    alu_res_valid = 1'b0;
    chk("t2_done", {op_done, res_valid, res_addr, res_data}, {2'b11, 3'd1, 8'd15});
    tick();          // IDLE
    chk("t2_idle", {busy, op_done}, 0);
    chk("t2_count", op_count, 2);
    tick();
    chk("t2_single_pulse", op_done, 0);
    stop = 1'b0;

    // ---- same-cycle ready+result; write to fetched index during FETCH
    address = 3'd2;
    pulse_start();
    prog_we = 1'b1; prog_addr = 3'd2; prog_data = {OPC_XOR, 8'h11, 8'h22};
    tick();          // ISSUE
    prog_we = 1'b0;
    chk("t3_old_contents", {alu_opcode, alu_a, alu_b}, {OPC_AND, 8'hF0, 8'h3C});
    alu_ready = 1'b1; alu_res_valid = 1'b1; alu_result = 8'h30;
    tick();          // DONE directly
    alu_ready = 1'b0; alu_res_valid = 1'b0;
    chk("t3_skip_wait", {op_done, res_valid, res_addr, res_data}, {2'b11, 3'd2, 8'h30});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_count", op_count, 3);
    alu_res_valid = 1'b1; alu_result = 8'hEE;   // ignored in IDLE
    tick();
    alu_res_valid = 1'b0;
    chk("t3_idle_ignore", {op_done, res_data}, {1'b0, 8'h30});

    // ---- reset during ISSUE clears everything including the store
    pulse_start();
    tick();          // ISSUE
    chk("t4_new_contents", {alu_valid, alu_opcode, alu_a, alu_b}, {1'b1, OPC_XOR, 8'h11, 8'h22});
    reset = 1'b0;
    #1;
    chk("t4_async_clear", {alu_valid, busy, res_addr, res_data, op_count}, 0);
    tick();
    reset = 1'b1;
    pulse_start();
    tick();
    chk("t4_store_zero", {alu_valid, alu_opcode, alu_a, alu_b}, {1'b1, 19'd0});
    alu_ready = 1'b1; alu_res_valid = 1'b1; alu_result = 8'd0;
    tick();
    alu_ready = 1'b0; alu_res_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // ---- continuous run, address stepping, ADDR_SETTLE = 2
    for (int k = 0; k < 7; k++)
      prog(seq[k], OPC_OR, 8'h10 + 8'(seq[k]), 8'h80 + 8'(seq[k]));
    address = seq[0];
    alu_ready = 1'b1;
    pulse_start();
    tick();          // ISSUE
    for (int i = 0; i < 7; i++) begin
      chk("t5_issue", {alu_valid, alu_a, alu_b},
          {1'b1, 8'h10 + 8'(seq[i]), 8'h80 + 8'(seq[i])});
      tick();        // WAIT
      alu_res_valid = 1'b1; alu_result = 8'h40 + 8'(i);
      tick();        // DONE
      alu_res_valid = 1'b0;
      chk("t5_done", {op_done, res_valid, res_addr, res_data},
          {2'b11, seq[i], 8'h40 + 8'(i)});
      chk("t5_count_pre", op_count, i);
      if (i < 6) begin
        address = seq[i+1];
        for (int s = 0; s < 3; s++) begin
          tick();    // SETTLE, SETTLE, FETCH
          chk("t5_settle", {alu_valid, busy, op_done}, 3'b010);
        end
        tick();      // ISSUE
      end else begin
        stop = 1'b1;
      end
    end
    tick();
    stop = 1'b0; alu_ready = 1'b0;
    chk("t5_final", {busy, op_count}, {1'b0, 8'd7});

`ifdef SEQ_TIMEOUT_EN
    // ---- watchdog: no result for 64 WAIT cycles
    address = 3'd3;
    pulse_start();
    tick();
    alu_ready = 1'b1;
    tick();          // WAIT
    alu_ready = 1'b0;
    repeat (63) tick();
    chk("t6_pre_timeout", {op_done, err, busy}, 3'b001);
    tick();
    chk("t6_timeout", {op_done, res_valid, err}, 3'b101);
    chk("t6_count", op_count, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_sticky", {busy, err, op_count}, {2'b01, 8'd7});
`else
    chk("err_tied_low", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Downstream consumer of the 3-bit operation address from the address generator.
- Fetches the instruction at that address from a local 8-entry program store and issues it to the ALU with a valid/ready handshake.
- Waits for the ALU result, publishes it, then pulses op_done so the address generator advances.
- After each op_done, waits a fixed settle time for the generator's registered address update before the next fetch.

Parameters:
- WIDTH, 8, ALU operand/result width in bits.
- ADDR_SETTLE, 2, cycles waited after op_done before sampling the new address (0 allowed).
- TIMEOUT_CYC, 64, watchdog limit in WAIT (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins sequencing from IDLE.
- stop  input  1  level; return to IDLE after the current op completes.
- address  input  3  current operation address from the address generator.
- prog_we  input  1  program store write enable.
- prog_addr  input  3  program store write index.
- prog_data  input  3+2*WIDTH  instruction {opcode[2:0], a[WIDTH], b[WIDTH]}.
- alu_valid  output  1  request to ALU.
- alu_ready  input  1  ALU accepts request.
- alu_opcode  output  3  opcode to ALU.
- alu_a, alu_b  output  WIDTH each  operands to ALU.
- alu_res_valid  input  1  ALU result valid.
- alu_result  input  WIDTH  ALU result.
- op_done  output  1  one-cycle pulse per completed op.
- res_valid  output  1  one-cycle pulse, coincident with op_done.
- res_addr  output  3  address of the completed op.
- res_data  output  WIDTH  captured ALU result.
- op_count  output  8  completed-op counter.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  sticky timeout flag (0 without SEQ_TIMEOUT_EN).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; program store cleared to all-zero; op_count=0; err=0.
- States: IDLE, FETCH, ISSUE, WAIT, DONE, SETTLE.
- IDLE: start=1 -> FETCH. No settle on the first op.
- FETCH (1 cycle): latch cur_addr=address, latch the instruction at address into issue registers -> ISSUE.
- ISSUE:
  - alu_valid=1; alu_opcode, alu_a and alu_b held stable until the handshake.
  - alu_ready=1 -> WAIT.
  - alu_ready=1 and alu_res_valid=1 in the same cycle -> capture alu_result and go directly to DONE.
- WAIT: alu_valid=0; alu_res_valid=1 -> capture alu_result -> DONE. alu_res_valid is ignored in every other state.
- DONE (1 cycle):
  - op_done=1, res_valid=1, res_addr=cur_addr, res_data=captured result; op_count increments (255 wraps to 0).
  - Next state: IDLE if stop=1, else SETTLE. If ADDR_SETTLE=0 and stop=0, next state is FETCH.
- SETTLE: count ADDR_SETTLE cycles -> FETCH. stop=1 during SETTLE -> IDLE.
- Latency: start sampled at edge N gives FETCH in cycle N+1 and alu_valid=1 in cycle N+2. With a single-cycle ALU, op_done is 2 cycles after the handshake.
- start while busy=1 is ignored. stop does not abort ISSUE or WAIT.
- res_data and res_addr hold their values between DONE pulses.
- Program store writes are accepted in any state. A FETCH in the same cycle as a write to the same index reads the old contents; the new value is visible from the next cycle.
- Reset asserted mid-operation immediately forces IDLE and clears everything, including the program store.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT. Reaching TIMEOUT_CYC sets err=1 (sticky until reset) and goes to DONE.
  - In that DONE: op_done pulses, res_valid stays 0, op_count does not increment.
- Undefined: no counter; WAIT holds indefinitely; err tied 0.

Decomposition:
- Package alu_seq_pkg:
  - state enum (6 states);
  - opcode typedef (3-bit);
  - instruction packed struct parameterised via WIDTH localparams;
  - OPC_* constants.
- Sub-module seq_prog_store: 8 x (3+2*WIDTH) register file with asynchronous clear, one synchronous write port and one combinational read port.
- FSM, watchdog and counters stay in the top level.

Test Plan:
- Program idx 0 = {ADD, 8'd3, 8'd4}, address=0, ALU ready and result on the cycle after the handshake, start -> alu_valid in cycle 2, alu_a=3, alu_b=4, op_done plus res_valid with res_addr=0, op_count=1.
- Hold alu_ready=0 for 5 cycles -> alu_valid stays 1 with a stable payload; the handshake on the 6th cycle -> WAIT.
- alu_ready and alu_res_valid in the same ISSUE cycle -> DONE the next cycle, with WAIT skipped.
- Run continuously with address stepping 0,1,2,6,7,5,4 after each op_done (ADDR_SETTLE=2) -> res_addr follows the same order; op_count reaches 7.
- Assert stop during WAIT -> the op completes, op_done pulses once, state returns to IDLE, busy=0. Assert reset during ISSUE -> alu_valid=0 immediately and the program store reads zero.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYC=64, no alu_res_valid -> err=1 after 64 WAIT cycles, op_done pulses, res_valid=0, op_count unchanged.
